local_history_predictor: RTL

- Parametrised two-level local-history (PAp-class) conditional branch direction predictor for the fetch stage.
- Per-PC local history table (LHT) is updated speculatively at predict time and repaired on misprediction.
- History-indexed pattern table (PHT) of saturating counters is trained at branch resolution.
- Generalises the previous PAp: configurable history length, counter width, fetch/update width and PHT index mode (concat or xor); adds an explicit init FSM and a same-cycle write-conflict policy.

---
 rtl/local_history_predictor_pkg.sv | 25 ++
 rtl/local_pred_sat_counter.sv | 19 +
 rtl/local_history_predictor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/local_history_predictor_pkg.sv
// Shared types and constants for the two-level local-history branch predictor.
// Typedefs are sized for the default configuration (256-entry LHT, 1024-entry PHT, 8-bit history).
package local_history_predictor_pkg;

   typedef logic [7:0] LhtIndexPath;
   typedef logic [9:0] PhtIndexPath;
   typedef logic [7:0] LocalHistPath;
   typedef logic [1:0] PhtCounterPath;

   typedef struct packed {
      LocalHistPath  hist;
      PhtCounterPath ctr;
   } LocalPredSnapshot;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } pred_state_e;

   // Weakly-taken value for a counter of the given width: MSB set, all other bits clear.
   function automatic int weak_taken_init(input int ctr_bits);
      return 1 << (ctr_bits - 1);
   endfunction

endpackage

// File: rtl/local_pred_sat_counter.sv
// Combinational saturating up/down counter step used to train PHT entries.
module local_pred_sat_counter #(
   parameter int CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr_i,
   input  logic                inc_i,
   output logic [CTR_BITS-1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
      end else if (ctr_i != '0) begin
         ctr_o = ctr_i - CTR_BITS'(1);
      end
   end

endmodule

// File: rtl/local_history_predictor.sv
// Two-level local-history (PAp) direction predictor: per-PC history table feeding a
// pattern table of saturating counters, speculative history update with mispredict repair.
module local_history_predictor
   import local_history_predictor_pkg::*;
#(
   parameter int FETCH_WIDTH    = 2,
   parameter int UPDATE_WIDTH   = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int INSN_ADDR_BITS = 2,
   parameter int LHT_ENTRIES    = 256,
   parameter int HIST_BITS      = 8,
   parameter int PHT_ENTRIES    = 1024,
   parameter int CTR_BITS       = 2,
   parameter int INDEX_MODE     = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               ready,
   input  logic                               stall,
   input  logic                               flush,
   input  logic                               lookup_valid,
   input  logic [ADDR_WIDTH-1:0]              lookup_pc,
   input  logic [FETCH_WIDTH-1:0]             btb_hit,
   input  logic [FETCH_WIDTH-1:0]             is_cond_br,
   output logic                               pred_valid,
   output logic [FETCH_WIDTH-1:0]             pred_taken,
   output logic [FETCH_WIDTH*HIST_BITS-1:0]   pred_hist,
   output logic [FETCH_WIDTH*CTR_BITS-1:0]    pred_ctr,
   input  logic [UPDATE_WIDTH-1:0]            upd_valid,
   input  logic [UPDATE_WIDTH*ADDR_WIDTH-1:0] upd_pc,
   input  logic [UPDATE_WIDTH-1:0]            upd_is_cond,
   input  logic [UPDATE_WIDTH-1:0]            upd_taken,
   input  logic [UPDATE_WIDTH-1:0]            upd_mispred,
   input  logic [UPDATE_WIDTH*HIST_BITS-1:0]  upd_hist,
   input  logic [UPDATE_WIDTH*CTR_BITS-1:0]   upd_ctr
);

   localparam int LHT_IDX_W = $clog2(LHT_ENTRIES);
   localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
   localparam int INIT_LAST = ((LHT_ENTRIES > PHT_ENTRIES) ? LHT_ENTRIES : PHT_ENTRIES) - 1;
   localparam int INIT_W    = (INIT_LAST > 0) ? $clog2(INIT_LAST + 1) : 1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(weak_taken_init(CTR_BITS));

   logic [HIST_BITS-1:0] lht [LHT_ENTRIES];
   logic [CTR_BITS-1:0]  pht [PHT_ENTRIES];

   function automatic logic [LHT_IDX_W-1:0] lht_idx(input logic [ADDR_WIDTH-1:0] pc);
      return pc[INSN_ADDR_BITS +: LHT_IDX_W];
   endfunction

   function automatic logic [PHT_IDX_W-1:0] pht_idx(input logic [ADDR_WIDTH-1:0] pc,
                                                    input logic [HIST_BITS-1:0]  hist);
      logic [ADDR_WIDTH+HIST_BITS-1:0] cat;
      logic [PHT_IDX_W-1:0]            pcb;
      cat = {ADDR_WIDTH'(pc >> INSN_ADDR_BITS), hist};
      pcb = PHT_IDX_W'(pc >> INSN_ADDR_BITS);
      if (INDEX_MODE == 0) return cat[PHT_IDX_W-1:0];
      return pcb ^ PHT_IDX_W'(hist);
   endfunction

   pred_state_e                             state_q, state_d;
   logic [INIT_W-1:0]                       init_idx_q, init_idx_d;
   logic                                    ready_q, ready_d;
   logic                                    pred_valid_q, pred_valid_d;
   logic [ADDR_WIDTH-1:0]                   pred_pc_q, pred_pc_d;
   logic [FETCH_WIDTH-1:0][HIST_BITS-1:0]   pred_hist_q, pred_hist_d;
   logic [FETCH_WIDTH-1:0][CTR_BITS-1:0]    pred_ctr_q, pred_ctr_d;

   logic                                    init_we;
   logic                                    accept;
   logic [FETCH_WIDTH-1:0][HIST_BITS-1:0]   rd_hist;
   logic [FETCH_WIDTH-1:0][CTR_BITS-1:0]    rd_ctr;
   logic [FETCH_WIDTH-1:0]                  ctr_msb;
   logic [FETCH_WIDTH-1:0]                  spec_we;
   logic [FETCH_WIDTH-1:0][LHT_IDX_W-1:0]   spec_idx;
   logic [FETCH_WIDTH-1:0][HIST_BITS-1:0]   spec_data;
   logic [UPDATE_WIDTH-1:0]                 pht_req, pht_we, lht_req, lht_we;
   logic [UPDATE_WIDTH-1:0][PHT_IDX_W-1:0]  upd_pht_idx;
   logic [UPDATE_WIDTH-1:0][LHT_IDX_W-1:0]  upd_lht_idx;
   logic [UPDATE_WIDTH-1:0][HIST_BITS-1:0]  upd_lht_data;
   logic [UPDATE_WIDTH-1:0][CTR_BITS-1:0]   upd_ctr_new;

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      ready_d    = ready_q;
      init_we    = 1'b0;
      if (state_q == ST_INIT) begin
         init_we = 1'b1;
         if (init_idx_q == INIT_W'(INIT_LAST)) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end else begin
            init_idx_d = init_idx_q + INIT_W'(1);
         end
      end
   end

   // Lookup reads happen in the accept cycle; the response cycle only sees registered snapshots.
   always_comb begin
      accept = lookup_valid && !stall && !flush && ready_q;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         rd_hist[i] = lht[lht_idx(lookup_pc + ADDR_WIDTH'(4 * i))];
         rd_ctr[i]  = pht[pht_idx(lookup_pc + ADDR_WIDTH'(4 * i), rd_hist[i])];
      end
      pred_pc_d    = accept ? lookup_pc : pred_pc_q;
      pred_hist_d  = accept ? rd_hist : pred_hist_q;
      pred_ctr_d   = accept ? rd_ctr : pred_ctr_q;
      pred_valid_d = flush ? 1'b0 : (stall ? pred_valid_q : accept);
   end

   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) ctr_msb[i] = pred_ctr_q[i][CTR_BITS-1];
   end

   assign pred_taken = pred_valid_q ? (btb_hit & ctr_msb) : '0;

   // Slot-ordered speculative shift; a later slot hitting an earlier slot's entry chains on its new value.
   always_comb begin
      logic                 stop;
      logic [HIST_BITS-1:0] base;
      stop = 1'b0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         spec_idx[i] = lht_idx(pred_pc_q + ADDR_WIDTH'(4 * i));
         base = pred_hist_q[i];
         for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (j < i && spec_we[j] && spec_idx[j] == spec_idx[i]) base = spec_data[j];
         end
         spec_we[i]   = pred_valid_q && !stall && !flush && !stop && btb_hit[i] && is_cond_br[i];
         spec_data[i] = {base[HIST_BITS-2:0], pred_taken[i]};
         if (pred_taken[i]) stop = 1'b1;
      end
   end

   for (genvar k = 0; k < UPDATE_WIDTH; k++) begin : g_ctr
      local_pred_sat_counter #(.CTR_BITS(CTR_BITS)) u_sat (
         .ctr_i (upd_ctr[k*CTR_BITS +: CTR_BITS]),
         .inc_i (upd_taken[k]),
         .ctr_o (upd_ctr_new[k])
      );
   end

   // Lowest update port wins when several target the same table entry.
   always_comb begin
      for (int k = 0; k < UPDATE_WIDTH; k++) begin
         upd_pht_idx[k]  = pht_idx(upd_pc[k*ADDR_WIDTH +: ADDR_WIDTH], upd_hist[k*HIST_BITS +: HIST_BITS]);
         upd_lht_idx[k]  = lht_idx(upd_pc[k*ADDR_WIDTH +: ADDR_WIDTH]);
         upd_lht_data[k] = {upd_hist[k*HIST_BITS +: HIST_BITS-1], upd_taken[k]};
         pht_req[k]      = ready_q && upd_valid[k];
         lht_req[k]      = pht_req[k] && upd_mispred[k] && upd_is_cond[k];
      end
      for (int k = 0; k < UPDATE_WIDTH; k++) begin
         pht_we[k] = pht_req[k];
         lht_we[k] = lht_req[k];
         for (int j = 0; j < UPDATE_WIDTH; j++) begin
            if (j < k && pht_req[j] && upd_pht_idx[j] == upd_pht_idx[k]) pht_we[k] = 1'b0;
            if (j < k && lht_req[j] && upd_lht_idx[j] == upd_lht_idx[k]) lht_we[k] = 1'b0;
         end
      end
   end

   // Repair writes are issued after speculative ones so they take precedence on a shared entry.
   always_ff @(posedge clk) begin
      if (init_we) begin
         if (32'(init_idx_q) < LHT_ENTRIES) lht[init_idx_q[LHT_IDX_W-1:0]] <= '0;
         if (32'(init_idx_q) < PHT_ENTRIES) pht[init_idx_q[PHT_IDX_W-1:0]] <= CTR_WEAK;
      end
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (spec_we[i]) lht[spec_idx[i]] <= spec_data[i];
      end
      for (int k = 0; k < UPDATE_WIDTH; k++) begin
         if (pht_we[k]) pht[upd_pht_idx[k]] <= upd_ctr_new[k];
         if (lht_we[k]) lht[upd_lht_idx[k]] <= upd_lht_data[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_INIT;
         init_idx_q   <= '0;
         ready_q      <= 1'b0;
         pred_valid_q <= 1'b0;
         pred_pc_q    <= '0;
         pred_hist_q  <= '0;
         pred_ctr_q   <= '0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         ready_q      <= ready_d;
         pred_valid_q <= pred_valid_d;
         pred_pc_q    <= pred_pc_d;
         pred_hist_q  <= pred_hist_d;
         pred_ctr_q   <= pred_ctr_d;
      end
   end

   assign ready      = ready_q;
   assign pred_valid = pred_valid_q;
   assign pred_hist  = pred_hist_q;
   assign pred_ctr   = pred_ctr_q;

endmodule
